// File: rtl/quant_dot_product.sv
// Quantized integer dot-product engine: zero-point removal, multiply, and
// accumulate over VEC_LEN element pairs, emitting one result pulse per vector.
module quant_dot_product #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clr_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [DATA_W-1:0] a_zp_i,
  input  logic signed [DATA_W-1:0] b_zp_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic signed [ACC_W-1:0]  dout_o
);

  // A single-element build still needs a one-bit counter to stay legal.
  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [PROD_W-1:0]  prod_r;
  logic                      pvld_r;
  logic                      pfirst_r;
  logic                      plast_r;
  logic signed [ACC_W-1:0]   acc_r;

  logic                      accept_s;
  logic                      cnt_last_s;
  logic signed [DATA_W:0]    da_s;
  logic signed [DATA_W:0]    db_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   sum_s;

  assign ready_o = (state_r != DRAIN);
  assign busy_o  = (state_r != IDLE) | pvld_r;

  // Element acceptance, operand differences and the running-sum update value.
  always_comb begin
    accept_s   = valid_i & ready_o;
    cnt_last_s = (cnt_r == LAST_CNT);
    da_s       = {a_i[DATA_W-1], a_i} - {a_zp_i[DATA_W-1], a_zp_i};
    db_s       = {b_i[DATA_W-1], b_i} - {b_zp_i[DATA_W-1], b_zp_i};
    prod_s     = PROD_W'(da_s) * PROD_W'(db_s);
    if (pfirst_r) begin
      sum_s = ACC_W'(prod_r);
    end else begin
      sum_s = acc_r + ACC_W'(prod_r);
    end
  end

  // Vector sequencing FSM and element counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        cnt_r <= cnt_last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= cnt_last_s ? DRAIN : ACC;
          end
        end
        ACC: begin
          if (accept_s && cnt_last_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Product stage: one multiply per accepted element, tagged with vector position.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prod_r   <= {PROD_W{1'b0}};
      pvld_r   <= 1'b0;
      pfirst_r <= 1'b0;
      plast_r  <= 1'b0;
    end else if (clr_i) begin
      pvld_r   <= 1'b0;
      pfirst_r <= 1'b0;
      plast_r  <= 1'b0;
    end else if (accept_s) begin
      prod_r   <= prod_s;
      pvld_r   <= 1'b1;
      pfirst_r <= (cnt_r == {CNT_W{1'b0}});
      plast_r  <= cnt_last_s;
    end else begin
      pvld_r   <= 1'b0;
    end
  end

  // Accumulate stage: the first product restarts the sum so vectors never mix.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_r   <= {ACC_W{1'b0}};
      dout_o  <= {ACC_W{1'b0}};
      valid_o <= 1'b0;
    end else if (clr_i) begin
      acc_r   <= {ACC_W{1'b0}};
      valid_o <= 1'b0;
    end else if (pvld_r) begin
      acc_r <= sum_s;
      if (plast_r) begin
        dout_o  <= sum_s;
        valid_o <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quant_dot_product.sv
// Scoreboard bench for quant_dot_product: an 8-element build and a 1-element build.
module tb_quant_dot_product;

  localparam int DW = 8;
  localparam int AW = 32;

  typedef struct {
    logic signed [AW-1:0] val;
    int                   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic signed [DW-1:0] a0 = '0, b0 = '0, az0 = '0, bz0 = '0;
  logic signed [DW-1:0] a1 = '0, b1 = '0, az1 = '0, bz1 = '0;
  logic ready0, busy0, valid0, ready1, busy1, valid1;
  logic signed [AW-1:0] dout0, dout1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_v0 = 1'b0, prev_v1 = 1'b0;
  int low_run = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quant_dot_product #(.VEC_LEN(8), .DATA_W(DW), .ACC_W(AW)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .valid_i(v0),
    .a_i(a0), .b_i(b0), .a_zp_i(az0), .b_zp_i(bz0),
    .ready_o(ready0), .busy_o(busy0), .valid_o(valid0), .dout_o(dout0)
  );

  quant_dot_product #(.VEC_LEN(1), .DATA_W(DW), .ACC_W(AW)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(1'b0), .valid_i(v1),
    .a_i(a1), .b_i(b1), .a_zp_i(az1), .b_zp_i(bz1),
    .ready_o(ready1), .busy_o(busy1), .valid_o(valid1), .dout_o(dout1)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result pulse appears.
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("unexpected_valid0", 64'sd1, 64'sd0);
      end else begin
        e0 = q0.pop_front();
        chk("dout0", dout0, e0.val);
        chk("latency0", cyc, e0.cyc);
      end
      chk("pulse_width0", prev_v0, 64'sd0);
    end
    if (valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("unexpected_valid1", 64'sd1, 64'sd0);
      end else begin
        e1 = q1.pop_front();
        chk("dout1", dout1, e1.val);
        chk("latency1", cyc, e1.cyc);
      end
      chk("pulse_width1", prev_v1, 64'sd0);
    end
    prev_v0 <= valid0;
    prev_v1 <= valid1;
  end

  // ready_o of the 8-element build must drop for exactly one cycle per vector.
  always @(negedge clk) begin
    if (rstn) begin
      if (!ready0) begin
        low_run <= low_run + 1;
      end else begin
        if (low_run != 0) chk("ready_low_len", low_run, 64'sd1);
        low_run <= 0;
      end
    end
  end

  task automatic send(input int sel, input int a, input int b, input int az,
                      input int bz, input bit last, input int expv);
    int t;
    t = 0;
    @(negedge clk);
    clr = 1'b0;
    while (((sel == 0) ? ready0 : ready1) !== 1'b1 && t < 20) begin
      v0 = 1'b0;
      v1 = 1'b0;
      t++;
      @(negedge clk);
    end
    if (t >= 20) chk("ready_timeout", 64'sd0, 64'sd1);
    if (last) begin
      if (sel == 0) q0.push_back('{AW'(expv), cyc + 2});
      else          q1.push_back('{AW'(expv), cyc + 2});
    end
    if (sel == 0) begin
      v0 = 1'b1; a0 = DW'(a); b0 = DW'(b); az0 = DW'(az); bz0 = DW'(bz);
    end else begin
      v1 = 1'b1; a1 = DW'(a); b1 = DW'(b); az1 = DW'(az); bz1 = DW'(bz);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
      clr = 1'b0;
    end
  endtask

  initial begin
    #1;
    chk("rst_ready", ready0, 64'sd1);
    chk("rst_busy", busy0, 64'sd0);
    chk("rst_valid", valid0, 64'sd0);
    chk("rst_dout", dout0, 64'sd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Basic: sum(1..8)*2 = 72.
    for (int i = 1; i <= 8; i++) send(0, i, 2, 0, 0, i == 8, 72);
    // Zero points: sum(a-3)*(0+1) = 12, then 8*(-255*-255) = 520200, back to back.
    for (int i = 1; i <= 8; i++) send(0, i, 0, 3, -1, i == 8, 12);
    for (int i = 1; i <= 8; i++) send(0, -128, -128, 127, 127, i == 8, 520200);
    idle(4);

    // Gapped vector, then back-to-back vector; dout must hold 8 meanwhile.
    for (int i = 1; i <= 8; i++) begin
      send(0, 1, 1, 0, 0, i == 8, 8);
      if (i != 8) idle(1);
    end
    for (int i = 1; i <= 8; i++) begin
      send(0, -1, 3, 0, 0, i == 8, -24);
      chk("dout_hold", dout0, 64'sd8);
    end

    // clr_i mid-vector drops the partial vector and the coincident element.
    for (int i = 1; i <= 5; i++) send(0, 7, 9, 0, 0, 1'b0, 0);
    @(negedge clk);
    v0 = 1'b1; a0 = 8'sd7; b0 = 8'sd9; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; v0 = 1'b0;
    chk("clr_busy", busy0, 64'sd0);
    chk("clr_valid", valid0, 64'sd0);
    chk("clr_dout_hold", dout0, -64'sd24);
    for (int i = 1; i <= 8; i++) send(0, 2, 2, 0, 0, i == 8, 32);
    idle(4);

    // Async reset after 4 accepts, asserted between edges.
    for (int i = 1; i <= 4; i++) send(0, 5, 5, 0, 0, 1'b0, 0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_dout", dout0, 64'sd0);
    chk("arst_valid", valid0, 64'sd0);
    chk("arst_busy", busy0, 64'sd0);
    chk("arst_ready", ready0, 64'sd1);
    v0 = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    for (int i = 1; i <= 8; i++) send(0, i, -i, 0, 0, i == 8, -204);
    idle(4);

    // Single-element build: every accept goes through DRAIN.
    send(1, -5, 7, 0, 0, 1'b1, -35);
    @(negedge clk);
    v1 = 1'b0;
    chk("len1_drain_ready", ready1, 64'sd0);
    chk("len1_drain_busy", busy1, 64'sd1);
    send(1, 127, -128, -128, 127, 1'b1, -65025);
    send(1, 3, 3, 1, 1, 1'b1, 4);
    idle(6);

    chk("q0_drained", q0.size(), 64'sd0);
    chk("q1_drained", q1.size(), 64'sd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
